twiddle_sequencer_12: RTL and testbench

TWIDDLE_SEQUENCER_12 -- requirements
Module: twiddle_sequencer_12

---
 rtl/twiddle_sequencer_12_pkg.sv | 30 +++
 rtl/twiddle_sequencer_12_valid_delay_line.sv | 37 +++
 rtl/twiddle_sequencer_12.sv | 129 ++++++++++++
 tb/tb_twiddle_sequencer_12.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/twiddle_sequencer_12_pkg.sv
// ============================================================================
// Module   : twiddle_sequencer_12_pkg
// Brief    : Shared constants and state encoding for the twiddle sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package twiddle_sequencer_12_pkg;

    localparam int c_NUM_PATHS     = 16;
    localparam int c_FRAME_BEATS   = 32;
    localparam int c_GROUP_BEATS   = 8;
    localparam int c_TW_ADDR_WIDTH = 9;
    localparam int c_MUL_LATENCY   = 2;

    // Sideband bit positions carried alongside the valid through the delay line
    localparam int c_SB_VALID = 0;
    localparam int c_SB_FIRST = 1;
    localparam int c_SB_LAST  = 2;
    localparam int c_SB_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/twiddle_sequencer_12_valid_delay_line.sv
// ============================================================================
// Module   : valid_delay_line
// Brief    : Fixed-depth shift register for valid/sideband bits, cleared by rst.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module valid_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_data = r_pipe[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/twiddle_sequencer_12.sv
// ============================================================================
// Module   : twiddle_sequencer_12
// Brief    : Frame sequencer driving twiddle ROM addresses and multiplier valids.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module twiddle_sequencer_12
    import twiddle_sequencer_12_pkg::*;
#(
    parameter int NUM_PARALLEL_PATHS = c_NUM_PATHS,
    parameter int FRAME_BEATS        = c_FRAME_BEATS,
    parameter int GROUP_BEATS        = c_GROUP_BEATS,
    parameter int TW_ADDR_WIDTH      = c_TW_ADDR_WIDTH,
    parameter int MUL_LATENCY        = c_MUL_LATENCY
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    input  logic                                              din_valid,
    output logic [NUM_PARALLEL_PATHS-1:0][TW_ADDR_WIDTH-1:0] tw_addr,
    output logic                                              mul_in_valid,
    output logic                                              mul_out_valid,
    output logic                                              frame_first,
    output logic                                              frame_last,
    output logic                                              busy,
    output logic                                              overrun
);

    localparam int c_CNT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam int c_DRN_W = (MUL_LATENCY > 0) ? $clog2(MUL_LATENCY + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(FRAME_BEATS - 1);
    localparam logic [c_DRN_W-1:0] c_DRN_LAST  = c_DRN_W'(MUL_LATENCY);

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_beat_cnt;
    logic [c_DRN_W-1:0]   r_drain_cnt;
    logic                 r_overrun;
    logic                 w_accept;
    logic [c_SB_WIDTH-1:0] w_sb_in;
    logic [c_SB_WIDTH-1:0] w_sb_out;

    assign w_accept = (r_state == ST_RUN) && din_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
            r_overrun   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (din_valid) begin
                        r_overrun <= 1'b1;
                    end
                    if (start) begin
                        r_state    <= ST_RUN;
                        r_beat_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (din_valid) begin
                        if (r_beat_cnt == c_LAST_BEAT) begin
                            r_state     <= ST_DRAIN;
                            r_beat_cnt  <= '0;
                            r_drain_cnt <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (din_valid) begin
                        r_overrun <= 1'b1;
                    end
                    // Stay long enough for the last beat to leave the multiplier
                    if (r_drain_cnt == c_DRN_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar p = 0; p < NUM_PARALLEL_PATHS; p++) begin : g_path
        assign tw_addr[p] = TW_ADDR_WIDTH'(((32'(r_beat_cnt) % 32'(GROUP_BEATS))
                                            * 32'(NUM_PARALLEL_PATHS)) + 32'(p));
    end

    assign w_sb_in[c_SB_VALID] = w_accept;
    assign w_sb_in[c_SB_FIRST] = w_accept && (r_beat_cnt == '0);
    assign w_sb_in[c_SB_LAST]  = w_accept && (r_beat_cnt == c_LAST_BEAT);

    // ROM read stage: ROM data lands one cycle after the address
    valid_delay_line #(
        .DEPTH (1),
        .WIDTH (1)
    ) u_rom_valid (
        .clk    (clk),
        .rst    (rst),
        .i_data (w_accept),
        .o_data (mul_in_valid)
    );

    valid_delay_line #(
        .DEPTH (1 + MUL_LATENCY),
        .WIDTH (c_SB_WIDTH)
    ) u_out_valid (
        .clk    (clk),
        .rst    (rst),
        .i_data (w_sb_in),
        .o_data (w_sb_out)
    );

    assign mul_out_valid = w_sb_out[c_SB_VALID];
    assign frame_first   = w_sb_out[c_SB_FIRST];
    assign frame_last    = w_sb_out[c_SB_LAST];
    assign busy          = (r_state != ST_IDLE);
    assign overrun       = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_twiddle_sequencer_12.sv
// ============================================================================
// Module   : tb_twiddle_sequencer_12
// Brief    : Scoreboard bench for twiddle_sequencer_12 with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_twiddle_sequencer_12;

    localparam int NP = 16;
    localparam int FB = 32;
    localparam int GB = 8;
    localparam int AW = 9;
    localparam int ML = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 din_valid;
    logic [NP-1:0][AW-1:0] tw_addr;
    logic                 mul_in_valid;
    logic                 mul_out_valid;
    logic                 frame_first;
    logic                 frame_last;
    logic                 busy;
    logic                 overrun;

    twiddle_sequencer_12 #(
        .NUM_PARALLEL_PATHS (NP),
        .FRAME_BEATS        (FB),
        .GROUP_BEATS        (GB),
        .TW_ADDR_WIDTH      (AW),
        .MUL_LATENCY        (ML)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .din_valid     (din_valid),
        .tw_addr       (tw_addr),
        .mul_in_valid  (mul_in_valid),
        .mul_out_valid (mul_out_valid),
        .frame_first   (frame_first),
        .frame_last    (frame_last),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit first;
        bit last;
    } exp_t;

    exp_t q_out[$];
    int   q_in[$];
    exp_t e_out;
    int   e_in;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;

    // Frame-level model: mode 0 idle, 1 collecting beats, 2 waiting for pipeline to empty
    int m_mode  = 0;
    int m_beat  = 0;
    int m_drain = 0;
    bit m_ovr   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit st, input bit dv, input bit rs);
        logic [NP-1:0][AW-1:0] exp_tw;
        start     = st;
        din_valid = dv;
        rst       = rs;
        if (rs) begin
            m_mode = 0;
            m_beat = 0;
            m_ovr  = 1'b0;
        end else begin
            case (m_mode)
                0: begin
                    if (dv) m_ovr = 1'b1;
                    if (st) begin
                        m_mode = 1;
                        m_beat = 0;
                    end
                end
                1: begin
                    if (dv) begin
                        for (int p = 0; p < NP; p++) begin
                            exp_tw[p] = AW'(((m_beat % GB) * NP + p) % (1 << AW));
                        end
                        n_tests++;
                        if (tw_addr !== exp_tw) begin
                            n_fail++;
                            $display("FAIL tw_addr beat %0d at cycle %0d: got %h expected %h",
                                     m_beat, cyc, tw_addr, exp_tw);
                        end
                        q_in.push_back(cyc + 1);
                        q_out.push_back('{cyc + 1 + ML, m_beat == 0, m_beat == FB - 1});
                        m_beat++;
                        if (m_beat == FB) begin
                            m_mode  = 2;
                            m_beat  = 0;
                            m_drain = 1 + ML;
                        end
                    end
                end
                default: begin
                    if (dv) m_ovr = 1'b1;
                    m_drain--;
                    if (m_drain == 0) m_mode = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
        if (rs) begin
            q_in.delete();
            q_out.delete();
        end
        chk("busy", {31'd0, busy}, {31'd0, m_mode != 0});
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (mul_in_valid === 1'b1) begin
                if (q_in.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL mul_in_valid spurious at cycle %0d: got 1 expected 0", cyc);
                end else begin
                    e_in = q_in.pop_front();
                    chk("mul_in_valid cycle", cyc, e_in);
                end
            end else if (q_in.size() != 0 && q_in[0] <= cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL mul_in_valid missing at cycle %0d: got %b expected 1", cyc, mul_in_valid);
                void'(q_in.pop_front());
            end

            if (mul_out_valid === 1'b1) begin
                if (q_out.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL mul_out_valid spurious at cycle %0d: got 1 expected 0", cyc);
                end else begin
                    e_out = q_out.pop_front();
                    chk("mul_out_valid cycle", cyc, e_out.cyc);
                    chk("frame_first", {31'd0, frame_first}, {31'd0, e_out.first});
                    chk("frame_last", {31'd0, frame_last}, {31'd0, e_out.last});
                end
            end else begin
                chk("idle sideband", {30'd0, frame_first, frame_last}, 32'd0);
                if (q_out.size() != 0 && q_out[0].cyc <= cyc) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL mul_out_valid missing at cycle %0d: got %b expected 1", cyc, mul_out_valid);
                    void'(q_out.pop_front());
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        din_valid = 1'b0;
        repeat (3) step(0, 0, 1);
        mon_en = 1'b1;

        for (int p = 0; p < NP; p++) begin
            chk("reset tw_addr", {23'd0, tw_addr[p]}, p);
        end
        chk("reset mul_in_valid", {31'd0, mul_in_valid}, 32'd0);
        chk("reset mul_out_valid", {31'd0, mul_out_valid}, 32'd0);

        // Back-to-back full frame
        step(1, 0, 0);
        repeat (FB) step(0, 1, 0);
        repeat (6) step(0, 0, 0);

        // Alternating gaps during RUN
        step(1, 0, 0);
        for (int i = 0; i < 2 * FB; i++) step(0, (i % 2) == 0, 0);
        repeat (6) step(0, 0, 0);

        // Beat in IDLE sets sticky overrun, held through a clean frame
        step(0, 1, 0);
        repeat (2) step(0, 0, 0);
        step(1, 0, 0);
        repeat (FB) step(0, 1, 0);
        repeat (6) step(0, 0, 0);
        step(0, 0, 1);

        // Reset on beat 20 aborts the frame; next frame restarts at beat 0
        step(1, 0, 0);
        repeat (20) step(0, 1, 0);
        step(0, 1, 1);
        repeat (5) step(0, 0, 0);
        step(1, 0, 0);
        repeat (FB) step(0, 1, 0);
        repeat (6) step(0, 0, 0);

        // Start held high: frames chain only after drain completes
        for (int i = 0; i < 2 * (FB + ML + 3) + 4; i++) step(1, m_mode == 1, 0);
        repeat (6) step(0, 0, 0);

        // Randomized soak
        for (int i = 0; i < 4000; i++) begin
            bit st, dv, rs;
            st = ($urandom_range(0, 7) == 0);
            dv = (m_mode == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 599) == 0);
            step(st, dv, rs);
        end
        repeat (8) step(0, 0, 0);

        chk("mul_in queue drained", q_in.size(), 32'd0);
        chk("mul_out queue drained", q_out.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
